// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard/forwarding bundle between the pipeline and the
// hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 3
);
  logic                  d_valid;
  logic [RW-1:0]         d_rs;
  logic [RW-1:0]         d_rt;
  logic                  d_use_rs;
  logic                  d_use_rt;
  logic [RW-1:0]         d_rd;
  logic                  d_we;
  logic                  d_is_load;
  logic                  flush;
  logic                  mem_busy;
  logic [XLEN-1:0]       rf_v1;
  logic [XLEN-1:0]       rf_v2;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [XLEN-1:0]       v1;
  logic [XLEN-1:0]       v2;
  logic                  stall;
  logic                  issue;
  logic [15:0]           stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
    output d_rd, d_we, d_is_load, flush, mem_busy,
    output rf_v1, rf_v2, stage_data,
    input  v1, v2, stall, issue, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
    input  d_rd, d_we, d_is_load, flush, mem_busy,
    input  rf_v1, rf_v2, stage_data,
    output v1, v2, stall, issue, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks DEPTH in-flight writers, forwards
// the youngest ready result and stalls decode on not-yet-ready loads.
module hazard_scoreboard #(
  parameter int XLEN     = 32,
  parameter int RW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic          vld;
    logic          we;
    logic          ld;
    logic [RW-1:0] rd;
  } ent_t;

  ent_t [DEPTH-1:0] tbl;
  logic [15:0]      cnt;
  logic             hz_rs;
  logic             hz_rt;
  logic [XLEN-1:0]  v1;
  logic [XLEN-1:0]  v2;
  logic             stall;
  logic             issue;

  function automatic logic writes(ent_t e, logic [RW-1:0] r);
    return e.vld && e.we && (e.rd == r) && (r != '0);
  endfunction

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    v1    = bus.rf_v1;
    v2    = bus.rf_v2;
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (writes(tbl[k], bus.d_rs)) begin
        v1    = bus.stage_data[k*XLEN +: XLEN];
        hz_rs = tbl[k].ld && (k < LOAD_LAT);
      end
      if (writes(tbl[k], bus.d_rt)) begin
        v2    = bus.stage_data[k*XLEN +: XLEN];
        hz_rt = tbl[k].ld && (k < LOAD_LAT);
      end
    end
  end

  assign stall = bus.mem_busy
               | (bus.d_valid
                  & ((hz_rs & bus.d_use_rs)
                   | (hz_rt & bus.d_use_rt)));
  assign issue = bus.d_valid & ~stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl <= '0;
      cnt <= '0;
    end else begin
      if (stall && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (!bus.mem_busy) begin
        tbl[0] <= '{vld: issue, we: bus.d_we,
                    ld: bus.d_is_load, rd: bus.d_rd};
        for (int k = 1; k < DEPTH; k++)
          tbl[k] <= tbl[k-1];
      end
    end
  end

  assign bus.v1        = v1;
  assign bus.v2        = v2;
  assign bus.stall     = stall;
  assign bus.issue     = issue;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard (XLEN=32, DEPTH=3,
// LOAD_LAT=2).
module tb_hazard_scoreboard;

  localparam logic [31:0] RF1 = 32'hF1F1_0001;
  localparam logic [31:0] RF2 = 32'hF2F2_0002;
  localparam logic [95:0] SD  = {32'hC2, 32'hB1, 32'hA0};

  typedef struct {
    string       name;
    logic [81:0] exp;
    logic [81:0] mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  exp_t        sb[$];
  exp_t        e;
  logic [81:0] obs;
  logic [15:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  hazard_scoreboard_if #(.XLEN(32), .RW(5), .DEPTH(3)) bus ();

  hazard_scoreboard #(
    .XLEN(32), .RW(5), .DEPTH(3), .LOAD_LAT(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void push(string n, logic s, logic i,
                               logic [31:0] a, logic [31:0] b,
                               logic mv);
    exp_t x;
    x.name = n;
    x.exp  = {s, i, a, b, exp_cnt};
    x.mask = mv ? {82{1'b1}} : {2'b11, 64'h0, 16'hFFFF};
    sb.push_back(x);
    if (s && exp_cnt != 16'hFFFF) exp_cnt++;
  endfunction

  task automatic idle();
    bus.d_valid    = 1'b0;
    bus.d_rs       = '0;
    bus.d_rt       = '0;
    bus.d_use_rs   = 1'b0;
    bus.d_use_rt   = 1'b0;
    bus.d_rd       = '0;
    bus.d_we       = 1'b0;
    bus.d_is_load  = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_busy   = 1'b0;
    bus.rf_v1      = RF1;
    bus.rf_v2      = RF2;
    bus.stage_data = SD;
  endtask

  task automatic drain();
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic dec(logic v, logic [4:0] rs, logic urs,
                     logic [4:0] rt, logic urt,
                     logic [4:0] rd, logic we, logic ld);
    bus.d_valid   = v;
    bus.d_rs      = rs;
    bus.d_use_rs  = urs;
    bus.d_rt      = rt;
    bus.d_use_rt  = urt;
    bus.d_rd      = rd;
    bus.d_we      = we;
    bus.d_is_load = ld;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: push("rst_idle", 0, 0, RF1, RF2, 1);
        1: begin
          dec(1, 8, 1, 9, 1, 0, 0, 0);
          push("rst_issue", 0, 1, RF1, RF2, 1);
        end
        2: begin
          dec(1, 8, 1, 9, 1, 0, 0, 0);
          bus.mem_busy = 1'b1;
          push("rst_busy", 1, 0, RF1, RF2, 1);
        end
        default: begin
          dec(1, 8, 1, 9, 1, 0, 0, 0);
          bus.flush = 1'b1;
          push("rst_flush", 0, 0, RF1, RF2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu_chain();
    drain();
    for (int s = 0; s < 2; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 1, 1, 2, 1, 8, 1, 0);
          push("alu_wr", 0, 1, RF1, RF2, 1);
        end
        default: begin
          bus.stage_data = {32'hC2, 32'hB1, 32'h11};
          dec(1, 8, 1, 2, 1, 0, 0, 0);
          push("alu_fwd", 0, 1, 32'h11, RF2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_youngest();
    drain();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 3, 0, 4, 0, 8, 1, 0);
          push("yng_wr1", 0, 1, RF1, RF2, 1);
        end
        1: begin
          dec(1, 3, 0, 4, 0, 8, 1, 0);
          push("yng_wr2", 0, 1, RF1, RF2, 1);
        end
        2: begin
          bus.stage_data = {32'hC2, 32'h22, 32'h33};
          dec(1, 8, 1, 3, 1, 0, 1, 0);
          push("yng_fwd", 0, 1, 32'h33, RF2, 1);
        end
        default: begin
          bus.stage_data = {32'hC2, 32'h22, 32'h55};
          dec(1, 0, 1, 8, 1, 0, 0, 0);
          push("yng_r0", 0, 1, RF1, 32'h22, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    drain();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 0, 0, 0, 0, 9, 1, 1);
          push("lu_lw", 0, 1, RF1, RF2, 1);
        end
        1: begin
          dec(1, 1, 1, 9, 1, 0, 0, 0);
          push("lu_stall1", 1, 0, RF1, RF2, 0);
        end
        2: begin
          dec(1, 1, 1, 9, 1, 0, 0, 0);
          push("lu_stall2", 1, 0, RF1, RF2, 0);
        end
        default: begin
          dec(1, 1, 1, 9, 1, 0, 0, 0);
          push("lu_fwd", 0, 1, RF1, 32'hC2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_busy();
    drain();
    for (int s = 0; s < 6; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 0, 0, 0, 0, 10, 1, 0);
          push("mb_wr", 0, 1, RF1, RF2, 1);
        end
        1: push("mb_bubble", 0, 0, RF1, RF2, 1);
        2, 3, 4: begin
          dec(1, 10, 1, 0, 0, 0, 0, 0);
          bus.mem_busy = 1'b1;
          push("mb_frozen", 1, 0, 32'hB1, RF2, 1);
        end
        default: begin
          dec(1, 10, 1, 0, 0, 0, 0, 0);
          push("mb_resume", 0, 1, 32'hB1, RF2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    drain();
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 0, 0, 0, 0, 0, 1, 1);
          push("fl_lw_r0", 0, 1, RF1, RF2, 1);
        end
        1: begin
          dec(1, 0, 1, 0, 0, 9, 1, 1);
          push("fl_r0_read", 0, 1, RF1, RF2, 1);
        end
        2: begin
          dec(1, 0, 0, 9, 1, 11, 1, 0);
          bus.flush = 1'b1;
          push("fl_hazard", 1, 0, RF1, RF2, 0);
        end
        3: begin
          dec(1, 0, 1, 0, 1, 12, 1, 0);
          bus.flush = 1'b1;
          push("fl_nohaz", 0, 0, RF1, RF2, 1);
        end
        default: begin
          dec(1, 11, 1, 12, 1, 0, 0, 0);
          push("fl_killed", 0, 1, RF1, RF2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    drain();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin
          dec(1, 0, 0, 0, 0, 9, 1, 1);
          push("rm_lw9", 0, 1, RF1, RF2, 1);
        end
        1: begin
          dec(1, 0, 0, 0, 0, 13, 1, 1);
          push("rm_lw13", 0, 1, RF1, RF2, 1);
        end
        2: begin
          reset = 1'b1;
          dec(1, 9, 1, 13, 1, 0, 0, 0);
          push("rm_pre", 1, 0, RF1, RF2, 0);
        end
        default: begin
          reset   = 1'b0;
          exp_cnt = '0;
          dec(1, 9, 1, 13, 1, 0, 0, 0);
          push("rm_post", 0, 1, RF1, RF2, 1);
        end
      endcase
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.stall, bus.issue, bus.v1, bus.v2, bus.stall_cnt};
      checks++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h want %h",
                 e.name, obs & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_cnt = '0;
    reset   = 1'b1;
    idle();
    test_reset();
    test_alu_chain();
    test_youngest();
    test_load_use();
    test_mem_busy();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
